// File: rtl/sum_accum_pkg.sv
// Shared types and constants for the frame-summing accumulator.
package sum_accum_pkg;

    localparam int SUM_W = 7;
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/sum_accum_sat_add.sv
// Combinational accumulator adder with an overflow output.
// SUM_ACCUM_SAT_EN selects whether an overflowing result clamps or wraps.
module sum_accum_sat_add
    import sum_accum_pkg::*;
#(
    parameter int ACC_W = 10
) (
    input  logic [ACC_W-1:0] a_i,
    input  logic [SUM_W-1:0] b_i,
    output logic [ACC_W-1:0] sum_o,
    output logic             ovf_o
);

    logic [ACC_W:0] full;

    assign full  = {1'b0, a_i} + {{(ACC_W+1-SUM_W){1'b0}}, b_i};
    assign ovf_o = full[ACC_W];

`ifdef SUM_ACCUM_SAT_EN
    assign sum_o = ovf_o ? {ACC_W{1'b1}} : full[ACC_W-1:0];
`else
    assign sum_o = full[ACC_W-1:0];
`endif

endmodule

// File: rtl/sum_accum.sv
// Accumulates FRAME_LEN accepted sums into one frame total with a valid/ready result port.
// Optional clamping on overflow is enabled by defining SUM_ACCUM_SAT_EN.
module sum_accum
    import sum_accum_pkg::*;
#(
    parameter int FRAME_LEN = 4,
    parameter int ACC_W     = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [SUM_W-1:0] in_sum,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             drop_flag,
    output logic             sat_flag
);

`ifdef SUM_ACCUM_SAT_EN
    localparam logic SAT_EN = 1'b1;
`else
    localparam logic SAT_EN = 1'b0;
`endif
    localparam logic [CNT_W-1:0] FRAME_LEN_C = CNT_W'(FRAME_LEN);

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               drop_q, drop_d;
    logic               sat_q, sat_d;

    logic               accept, handshake, new_frame;
    logic [ACC_W-1:0]   add_a, add_sum;
    logic [CNT_W-1:0]   base_cnt;
    logic               add_ovf;

    assign in_ready  = (state_q != DONE) | out_ready;
    assign out_valid = (state_q == DONE);
    assign out_acc   = acc_q;
    assign drop_flag = drop_q;
    assign sat_flag  = sat_q;

    assign accept    = in_valid & in_ready & ~clear;
    assign handshake = (state_q == DONE) & out_ready;
    // A result leaving this cycle frees the accumulator for a same-cycle first sample.
    assign new_frame = (state_q == IDLE) | handshake;
    assign add_a     = handshake ? '0 : acc_q;
    assign base_cnt  = handshake ? '0 : cnt_q;

    sum_accum_sat_add #(.ACC_W(ACC_W)) u_add (
        .a_i   (add_a),
        .b_i   (in_sum),
        .sum_o (add_sum),
        .ovf_o (add_ovf)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        drop_d  = drop_q;
        sat_d   = sat_q;
        if (clear) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            drop_d  = 1'b0;
            sat_d   = 1'b0;
        end else begin
            if (in_valid && !in_ready) begin
                drop_d = 1'b1;
            end
            if (accept) begin
                acc_d   = add_sum;
                cnt_d   = base_cnt + 1'b1;
                state_d = (cnt_d == FRAME_LEN_C) ? DONE : ACCUM;
                sat_d   = (new_frame ? 1'b0 : sat_q) | (add_ovf & SAT_EN);
            end else if (handshake) begin
                state_d = IDLE;
                acc_d   = '0;
                cnt_d   = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            drop_q  <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
            sat_q   <= sat_d;
        end
    end

endmodule

// File: tb/tb_sum_accum.sv
// Self-checking bench for sum_accum: default instance plus an ACC_W=8 instance on shared inputs.
module tb_sum_accum;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic [6:0] in_sum = '0;
    logic       out_ready = 1'b0;

    logic       in_ready, out_valid, drop_flag, sat_flag;
    logic [9:0] out_acc;
    logic       in_ready8, out_valid8, drop8, sat8;
    logic [7:0] out_acc8;

    int errors = 0;
    int checks = 0;
    logic [9:0] exp_q[$];
    logic [7:0] exp8_q[$];

`ifdef SUM_ACCUM_SAT_EN
    localparam logic [7:0] SAT8_ACC  = 8'd255;
    localparam logic       SAT8_FLAG = 1'b1;
`else
    localparam logic [7:0] SAT8_ACC  = 8'd252;
    localparam logic       SAT8_FLAG = 1'b0;
`endif

    always #5 clk = ~clk;

    sum_accum dut (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_sum(in_sum),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_acc(out_acc), .drop_flag(drop_flag), .sat_flag(sat_flag)
    );

    sum_accum #(.ACC_W(8)) dut8 (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_sum(in_sum),
        .in_ready(in_ready8), .out_valid(out_valid8), .out_ready(out_ready),
        .out_acc(out_acc8), .drop_flag(drop8), .sat_flag(sat8)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [9:0] pop_exp();
        if (exp_q.size() == 0) return 'x;
        return exp_q.pop_front();
    endfunction

    function automatic logic [7:0] pop_exp8();
        if (exp8_q.size() == 0) return 'x;
        return exp8_q.pop_front();
    endfunction

    task automatic idle_clear();
        in_valid = 1'b0; out_ready = 1'b0; clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_acc !== 10'd0) begin errors++; $display("FAIL reset_out_acc got=%0d exp=0", out_acc); end
        checks++; if (drop_flag !== 1'b0) begin errors++; $display("FAIL reset_drop got=%b exp=0", drop_flag); end
        checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL reset_sat got=%b exp=0", sat_flag); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        #11 reset = 1'b0;
        step();
    endtask

    task automatic test_basic();
        logic [6:0] s[4] = '{7'd3, 7'd5, 7'd7, 7'd9};
        logic [9:0] e;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_sum = s[i];
            if (i == 3) exp_q.push_back(10'd24);
            step();
            if (i == 2) begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got=%b exp=0", out_valid); end
            end
        end
        in_valid = 1'b0;
        e = pop_exp();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
        checks++; if (out_acc !== e) begin errors++; $display("FAIL basic_acc got=%0d exp=%0d", out_acc, e); end
        step();
        checks++; if (out_valid !== 1'b0 || out_acc !== 10'd0) begin
            errors++; $display("FAIL basic_idle got valid=%b acc=%0d exp valid=0 acc=0", out_valid, out_acc); end
    endtask

    task automatic test_drop();
        logic [6:0] s[4] = '{7'd3, 7'd5, 7'd7, 7'd9};
        logic [9:0] e;
        idle_clear();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_sum = s[i];
            step();
        end
        exp_q.push_back(10'd24);
        in_sum = 7'd10;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL drop_in_ready got=%b exp=0", in_ready); end
        step();
        in_valid = 1'b0;
        e = pop_exp();
        checks++; if (drop_flag !== 1'b1) begin errors++; $display("FAIL drop_flag got=%b exp=1", drop_flag); end
        checks++; if (out_valid !== 1'b1 || out_acc !== e) begin
            errors++; $display("FAIL drop_hold got valid=%b acc=%0d exp valid=1 acc=%0d", out_valid, out_acc, e); end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL drop_ready_comb got=%b exp=1", in_ready); end
        step();
        checks++; if (out_valid !== 1'b0 || drop_flag !== 1'b1) begin
            errors++; $display("FAIL drop_after_hs got valid=%b drop=%b exp valid=0 drop=1", out_valid, drop_flag); end
        idle_clear();
        checks++; if (drop_flag !== 1'b0) begin errors++; $display("FAIL drop_clear got=%b exp=0", drop_flag); end
    endtask

    task automatic test_sat();
        logic [9:0] e;
        logic [7:0] e8;
        idle_clear();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_sum = 7'd127;
            step();
        end
        exp_q.push_back(10'd508);
        exp8_q.push_back(SAT8_ACC);
        e = pop_exp();
        e8 = pop_exp8();
        checks++; if (out_valid8 !== 1'b1 || out_acc8 !== e8) begin
            errors++; $display("FAIL sat_acc8 got valid=%b acc=%0d exp valid=1 acc=%0d", out_valid8, out_acc8, e8); end
        checks++; if (sat8 !== SAT8_FLAG) begin errors++; $display("FAIL sat_flag8 got=%b exp=%b", sat8, SAT8_FLAG); end
        checks++; if (out_acc !== e || sat_flag !== 1'b0) begin
            errors++; $display("FAIL sat_acc10 got acc=%0d sat=%b exp acc=%0d sat=0", out_acc, sat_flag, e); end
        in_sum = 7'd1;
        step();
        in_valid = 1'b0;
        checks++; if (sat8 !== 1'b0 || out_valid8 !== 1'b0 || out_acc8 !== 8'd1) begin
            errors++; $display("FAIL sat_newframe got sat=%b valid=%b acc=%0d exp sat=0 valid=0 acc=1", sat8, out_valid8, out_acc8); end
        idle_clear();
    endtask

    task automatic test_clear();
        logic [9:0] e;
        out_ready = 1'b1;
        in_valid = 1'b1; in_sum = 7'd2; step();
        in_sum = 7'd2; step();
        clear = 1'b1; in_sum = 7'd50; step();
        clear = 1'b0;
        checks++; if (out_acc !== 10'd0 || drop_flag !== 1'b0) begin
            errors++; $display("FAIL clear_state got acc=%0d drop=%b exp acc=0 drop=0", out_acc, drop_flag); end
        for (int i = 0; i < 4; i++) begin
            in_sum = 7'd1;
            if (i == 3) exp_q.push_back(10'd4);
            step();
        end
        in_valid = 1'b0;
        e = pop_exp();
        checks++; if (out_valid !== 1'b1 || out_acc !== e || drop_flag !== 1'b0) begin
            errors++; $display("FAIL clear_frame got valid=%b acc=%0d drop=%b exp valid=1 acc=%0d drop=0", out_valid, out_acc, drop_flag, e); end
        step();
    endtask

    task automatic test_async_reset();
        logic [6:0] s[4] = '{7'd3, 7'd5, 7'd7, 7'd9};
        logic [9:0] e;
        idle_clear();
        out_ready = 1'b1;
        in_valid = 1'b1; in_sum = 7'd3; step();
        in_sum = 7'd5; step();
        in_valid = 1'b0;
        checks++; if (out_acc !== 10'd8) begin errors++; $display("FAIL areset_pre got=%0d exp=8", out_acc); end
        #3 reset = 1'b1;
        #1;
        checks++; if (out_acc !== 10'd0 || out_valid !== 1'b0 || drop_flag !== 1'b0 || sat_flag !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL areset_now got acc=%0d valid=%b drop=%b sat=%b rdy=%b exp 0 0 0 0 1",
                               out_acc, out_valid, drop_flag, sat_flag, in_ready); end
        #1 reset = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_sum = s[i];
            if (i == 3) exp_q.push_back(10'd24);
            step();
        end
        in_valid = 1'b0;
        e = pop_exp();
        checks++; if (out_valid !== 1'b1 || out_acc !== e) begin
            errors++; $display("FAIL areset_frame got valid=%b acc=%0d exp valid=1 acc=%0d", out_valid, out_acc, e); end
        step();
    endtask

    task automatic test_back_to_back();
        logic [6:0] s[4] = '{7'd3, 7'd5, 7'd7, 7'd9};
        logic [9:0] e;
        idle_clear();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_sum = s[i];
            step();
        end
        in_valid = 1'b0;
        exp_q.push_back(10'd24);
        e = pop_exp();
        checks++; if (out_valid !== 1'b1 || out_acc !== e) begin
            errors++; $display("FAIL b2b_first got valid=%b acc=%0d exp valid=1 acc=%0d", out_valid, out_acc, e); end
        out_ready = 1'b1; in_valid = 1'b1; in_sum = 7'd6;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready got=%b exp=1", in_ready); end
        step();
        checks++; if (drop_flag !== 1'b0 || out_valid !== 1'b0 || out_acc !== 10'd6) begin
            errors++; $display("FAIL b2b_start got drop=%b valid=%b acc=%0d exp drop=0 valid=0 acc=6", drop_flag, out_valid, out_acc); end
        for (int i = 0; i < 3; i++) begin
            in_sum = 7'd1;
            if (i == 2) exp_q.push_back(10'd9);
            step();
        end
        in_valid = 1'b0;
        e = pop_exp();
        checks++; if (out_valid !== 1'b1 || out_acc !== e) begin
            errors++; $display("FAIL b2b_second got valid=%b acc=%0d exp valid=1 acc=%0d", out_valid, out_acc, e); end
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_drop();
        test_sat();
        test_clear();
        test_async_reset();
        test_back_to_back();
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
